// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory path: access widths, LSU states and
// the store lane helpers used by the load/store unit.
package riscv_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b011;
    localparam logic [2:0] MEM_HU = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Unsigned widths have no store form, and modes above HU are undefined.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [2:0] mode,
                                           input logic [1:0] off);
        logic r;
        case (mode)
            MEM_B:   r = 1'b0;
            MEM_BU:  r = is_store;
            MEM_H:   r = off[0];
            MEM_HU:  r = is_store | off[0];
            MEM_W:   r = (off != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] mode,
                                            input logic [1:0] off);
        logic [3:0] r;
        case (mode)
            MEM_B:   r = 4'b0001 << off;
            MEM_H:   r = off[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0]  mode,
                                               input logic [31:0] data);
        logic [31:0] r;
        case (mode)
            MEM_B:   r = {4{data[7:0]}};
            MEM_H:   r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it
// according to the load mode.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_mode,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_mode)
            MEM_B:   o_data = {{24{w_byte[7]}}, w_byte};
            MEM_H:   o_data = {{16{w_half[15]}}, w_half};
            MEM_BU:  o_data = {24'h0, w_byte};
            MEM_HU:  o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory port: latches one load/store from the core, runs a
// valid/ready request plus response on the data bus, and stalls until it retires.
//
// state | meaning
// IDLE  | no access in flight; accepts an aligned request from the core
// REQ   | bus_valid high, fields held until bus_ready
// WAIT  | request accepted, waiting for bus_rsp_valid
// DONE  | one-cycle retire slot; rdata/bus_err valid, stall low
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mem_mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [2:0]    r_mode;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_valid;

    logic          w_access;
    logic          w_misalign;
    logic          w_start;
    logic          w_timeout;
    logic [31:0]   w_load_ext;

    assign w_access   = rd_en | wr_en;
    assign w_misalign = w_access & is_misaligned(wr_en, mem_mode, addr[1:0]);
    assign w_start    = (r_state == IDLE) & w_access & ~w_misalign;
    assign w_timeout  = (r_cnt == TC_LAST);

    load_align u_load_align (
        .i_word (bus_rdata),
        .i_off  (r_addr[1:0]),
        .i_mode (r_mode),
        .o_data (w_load_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_mode  <= MEM_B;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_addr  <= addr;
                        r_mode  <= mem_mode;
                        r_we    <= wr_en;
                        r_be    <= wr_en ? store_be(mem_mode, addr[1:0]) : 4'b1111;
                        r_wdata <= wr_en ? store_data(mem_mode, wdata) : 32'h0;
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    // A response arriving alongside bus_ready is not a legal
                    // completion, so only the handshake is honoured here.
                    if (w_timeout) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (bus_ready) begin
                            r_valid <= 1'b0;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (bus_rsp_valid) begin
                            r_rdata <= r_we ? 32'h0 : w_load_ext;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall     = w_start | (r_state == REQ) | (r_state == WAIT);
    assign misalign  = w_misalign;
    assign rdata     = r_rdata;
    assign bus_err   = r_err;
    assign bus_valid = r_valid;
    assign bus_we    = r_we;
    assign bus_addr  = {r_addr[31:2], 2'b00};
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, slow bus,
// timeout and reset mid-access, all against hand-computed values.
module tb_load_store_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [2:0]  mem_mode;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign, bus_err, bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .mem_mode(mem_mode),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .misalign(misalign),
        .bus_err(bus_err), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive point is 1ns after the rising edge; sampling happens on the falling edge.
    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [2:0] mode,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rword, input int ready_lat,
                             input bit respond,
                             output int stall_cyc, output int valid_cyc, output int hs,
                             output logic [3:0] be, output logic [31:0] wdat,
                             output logic we, output logic [31:0] rd_out,
                             output logic err, output bit done);
        int k;
        int phase;
        stall_cyc = 0; valid_cyc = 0; hs = 0; be = '0; wdat = '0; we = 1'b0;
        rd_out = '0; err = 1'b0; done = 1'b0; k = 0; phase = 0;
        drive_pt();
        rd_en = rd; wr_en = wr; mem_mode = mode; addr = a; wdata = wd;
        bus_ready = 1'b0; bus_rsp_valid = 1'b0;
        #4;
        if (stall) stall_cyc++;
        for (int c = 0; c < 300; c++) begin
            drive_pt();
            rd_en = 1'b0; wr_en = 1'b0; mem_mode = MEM_W;
            addr = 32'hDEAD_BEEF; wdata = 32'h5555_5555;
            bus_ready = bus_valid && (k >= ready_lat);
            bus_rsp_valid = (phase == 1) && respond;
            bus_rdata = rword;
            #4;
            if (stall) stall_cyc++;
            if (bus_valid) begin
                if (k == 0) begin
                    be = bus_be; wdat = bus_wdata; we = bus_we;
                end
                chk("addr_hold", bus_addr, {a[31:2], 2'b00});
                valid_cyc++;
                k++;
                if (bus_ready) begin
                    hs++;
                    phase = 1;
                end
            end else if (phase == 1 && bus_rsp_valid) begin
                phase = 2;
            end
            if (!stall) begin
                done = 1'b1;
                rd_out = rdata;
                err = bus_err;
                break;
            end
        end
        bus_ready = 1'b0;
        bus_rsp_valid = 1'b0;
    endtask

    int          s_cyc, v_cyc, n_hs;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_rd;
    logic        o_we, o_err;
    bit          o_done;

    logic        mis_wr   [4];
    logic [2:0]  mis_mode [4];
    logic [31:0] mis_addr [4];

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; mem_mode = MEM_B;
        addr = '0; wdata = '0; bus_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #4;
        chk("rst_stall",   {31'h0, stall},     32'h0);
        chk("rst_valid",   {31'h0, bus_valid}, 32'h0);
        chk("rst_we",      {31'h0, bus_we},    32'h0);
        chk("rst_be",      {28'h0, bus_be},    32'h0);
        chk("rst_err",     {31'h0, bus_err},   32'h0);
        chk("rst_rdata",   rdata,              32'h0);
        chk("rst_addr",    bus_addr,           32'h0);
        chk("rst_wdata",   bus_wdata,          32'h0);

        // LB from top byte lane, zero-wait bus
        do_access(1'b1, 1'b0, MEM_B, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 0, 1'b1,
                  s_cyc, v_cyc, n_hs, o_be, o_wd, o_we, o_rd, o_err, o_done);
        chk("lb_done",  {31'h0, o_done}, 32'h1);
        chk("lb_stall", s_cyc,           32'd3);
        chk("lb_hs",    n_hs,            32'd1);
        chk("lb_be",    {28'h0, o_be},   32'hF);
        chk("lb_we",    {31'h0, o_we},   32'h0);
        chk("lb_rdata", o_rd,            32'hFFFF_FF80);
        chk("lb_err",   {31'h0, o_err},  32'h0);

        // SH upper half
        do_access(1'b0, 1'b1, MEM_H, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 1'b1,
                  s_cyc, v_cyc, n_hs, o_be, o_wd, o_we, o_rd, o_err, o_done);
        chk("sh_done",  {31'h0, o_done}, 32'h1);
        chk("sh_stall", s_cyc,           32'd3);
        chk("sh_be",    {28'h0, o_be},   32'hC);
        chk("sh_wdata", o_wd,            32'hABCD_ABCD);
        chk("sh_we",    {31'h0, o_we},   32'h1);

        // Both enables: the store wins; SB to lane 3
        do_access(1'b1, 1'b1, MEM_B, 32'h0000_0503, 32'h0000_00AB, 32'h0, 0, 1'b1,
                  s_cyc, v_cyc, n_hs, o_be, o_wd, o_we, o_rd, o_err, o_done);
        chk("sb_we",    {31'h0, o_we},   32'h1);
        chk("sb_be",    {28'h0, o_be},   32'h8);
        chk("sb_wdata", o_wd,            32'hABAB_ABAB);

        // LH sign-extends the low half
        do_access(1'b1, 1'b0, MEM_H, 32'h0000_0600, 32'h0, 32'h1234_8765, 0, 1'b1,
                  s_cyc, v_cyc, n_hs, o_be, o_wd, o_we, o_rd, o_err, o_done);
        chk("lh_rdata", o_rd, 32'hFFFF_8765);

        // Misaligned or illegal accesses never reach the bus
        mis_wr[0] = 1'b0; mis_mode[0] = MEM_W;  mis_addr[0] = 32'h0000_0101;
        mis_wr[1] = 1'b1; mis_mode[1] = MEM_BU; mis_addr[1] = 32'h0000_0000;
        mis_wr[2] = 1'b0; mis_mode[2] = 3'b101; mis_addr[2] = 32'h0000_0000;
        mis_wr[3] = 1'b1; mis_mode[3] = MEM_H;  mis_addr[3] = 32'h0000_0201;
        for (int i = 0; i < 4; i++) begin
            drive_pt();
            rd_en = ~mis_wr[i]; wr_en = mis_wr[i]; mem_mode = mis_mode[i]; addr = mis_addr[i];
            #4;
            chk("mis_flag",  {31'h0, misalign},  32'h1);
            chk("mis_stall", {31'h0, stall},     32'h0);
            drive_pt();
            rd_en = 1'b0; wr_en = 1'b0;
            #4;
            chk("mis_valid", {31'h0, bus_valid}, 32'h0);
        end

        // LHU with bus_ready held off for 5 cycles
        do_access(1'b1, 1'b0, MEM_HU, 32'h0000_0302, 32'h0, 32'h8001_1234, 5, 1'b1,
                  s_cyc, v_cyc, n_hs, o_be, o_wd, o_we, o_rd, o_err, o_done);
        chk("slow_vcyc",  v_cyc, 32'd6);
        chk("slow_hs",    n_hs,  32'd1);
        chk("slow_stall", s_cyc, 32'd8);
        chk("slow_rdata", o_rd,  32'h0000_8001);

        // No response: forced completion after 16 cycles in REQ+WAIT
        do_access(1'b1, 1'b0, MEM_W, 32'h0000_0400, 32'h0, 32'h1111_1111, 0, 1'b0,
                  s_cyc, v_cyc, n_hs, o_be, o_wd, o_we, o_rd, o_err, o_done);
        chk("to_done",  {31'h0, o_done}, 32'h1);
        chk("to_stall", s_cyc,           32'd17);
        chk("to_err",   {31'h0, o_err},  32'h1);
        chk("to_rdata", o_rd,            32'h0);
        drive_pt();
        bus_rsp_valid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #4;
        chk("late_stall", {31'h0, stall},     32'h0);
        chk("late_valid", {31'h0, bus_valid}, 32'h0);
        drive_pt();
        bus_rsp_valid = 1'b0;
        #4;
        chk("late_valid2", {31'h0, bus_valid}, 32'h0);
        chk("late_stall2", {31'h0, stall},     32'h0);

        // Reset while WAITing drops the access
        drive_pt();
        rd_en = 1'b1; mem_mode = MEM_B; addr = 32'h0000_0010;
        #4;
        drive_pt();
        rd_en = 1'b0; bus_ready = 1'b1;
        #4;
        chk("rw_req_valid", {31'h0, bus_valid}, 32'h1);
        drive_pt();
        bus_ready = 1'b0; rst = 1'b1;
        #4;
        drive_pt();
        rst = 1'b0;
        #4;
        chk("rw_stall", {31'h0, stall},     32'h0);
        chk("rw_valid", {31'h0, bus_valid}, 32'h0);
        do_access(1'b1, 1'b0, MEM_BU, 32'h0000_0001, 32'h0, 32'h0000_F000, 0, 1'b1,
                  s_cyc, v_cyc, n_hs, o_be, o_wd, o_we, o_rd, o_err, o_done);
        chk("lbu_stall", s_cyc, 32'd3);
        chk("lbu_rdata", o_rd,  32'h0000_00F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
